// File: rtl/operand_entry_ctrl.sv
// Keypad operand entry controller: collects decimal digits, commits operands A and B,
// and presents their sum; every output is registered.
module operand_entry_ctrl #(
  parameter int unsigned MAX_DIGITS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [9:0]  operand_a,
  output logic [9:0]  operand_b,
  output logic [10:0] sum,
  output logic [13:0] disp_value,
  output logic [1:0]  digit_count,
  output logic [1:0]  state_o,
  output logic        result_valid
);

  typedef enum logic [1:0] {
    ENTER_A     = 2'b00,
    ENTER_B     = 2'b01,
    SHOW_RESULT = 2'b10
  } state_t;

  localparam logic [1:0] MAX_CNT = 2'(MAX_DIGITS);

  localparam logic [3:0] KEY_A = 4'd10;
  localparam logic [3:0] KEY_B = 4'd11;
  localparam logic [3:0] KEY_C = 4'd12;
  localparam logic [3:0] KEY_D = 4'd13;

  state_t      state, state_n;
  logic [9:0]  acc, acc_n;
  logic [9:0]  opa_n, opb_n;
  logic [10:0] sum_n;
  logic [1:0]  cnt_n;
  logic        rv_n;
  logic [13:0] disp_n;
  logic        is_digit;
  logic [9:0]  acc_shift;

  assign is_digit  = (key_code < 4'd10);
  // acc*10 + digit; entries never exceed 999, so the 10-bit wrap is never reached
  assign acc_shift = (acc << 3) + (acc << 1) + {6'b0, key_code};
  assign state_o   = state;

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = digit_count;
    opa_n   = operand_a;
    opb_n   = operand_b;
    sum_n   = sum;
    rv_n    = 1'b0;
    if (key_valid) begin
      if (is_digit) begin
        if (state == SHOW_RESULT) begin
          acc_n   = {6'b0, key_code};
          cnt_n   = 2'd1;
          state_n = ENTER_A;
        end else if (digit_count < MAX_CNT) begin
          acc_n = acc_shift;
          cnt_n = digit_count + 2'd1;
        end
      end else begin
        unique case (key_code)
          KEY_A: if (state == ENTER_A && digit_count != 2'd0) begin
            opa_n   = acc;
            acc_n   = '0;
            cnt_n   = '0;
            state_n = ENTER_B;
          end
          KEY_B: if (state == ENTER_B && digit_count != 2'd0) begin
            opb_n   = acc;
            sum_n   = {1'b0, operand_a} + {1'b0, acc};
            acc_n   = '0;
            cnt_n   = '0;
            rv_n    = 1'b1;
            state_n = SHOW_RESULT;
          end
          KEY_C: begin
            acc_n = '0;
            cnt_n = '0;
          end
          KEY_D: begin
            acc_n   = '0;
            cnt_n   = '0;
            opa_n   = '0;
            opb_n   = '0;
            sum_n   = '0;
            state_n = ENTER_A;
          end
          default: ;
        endcase
      end
    end
    disp_n = (state_n == SHOW_RESULT) ? {3'b0, sum_n} : {4'b0, acc_n};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ENTER_A;
      acc          <= '0;
      digit_count  <= '0;
      operand_a    <= '0;
      operand_b    <= '0;
      sum          <= '0;
      disp_value   <= '0;
      result_valid <= 1'b0;
    end else begin
      state        <= state_n;
      acc          <= acc_n;
      digit_count  <= cnt_n;
      operand_a    <= opa_n;
      operand_b    <= opb_n;
      sum          <= sum_n;
      disp_value   <= disp_n;
      result_valid <= rv_n;
    end
  end

endmodule

// File: tb/tb_operand_entry_ctrl.sv
// Scoreboard bench for operand_entry_ctrl: a digit-list reference model predicts every
// cycle's outputs; a monitor pops and compares one cycle after each driven cycle.
module tb_operand_entry_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [9:0]  operand_a, operand_b;
  logic [10:0] sum;
  logic [13:0] disp_value;
  logic [1:0]  digit_count, state_o;
  logic        result_valid;

  localparam int MAXD = 3;

  operand_entry_ctrl #(.MAX_DIGITS(MAXD)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .operand_a(operand_a), .operand_b(operand_b), .sum(sum),
    .disp_value(disp_value), .digit_count(digit_count),
    .state_o(state_o), .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a, b, s, d, c, st, rv;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int errors  = 0;

  // reference model: phase 0=entering A, 1=entering B, 2=showing result
  int m_phase, m_a, m_b, m_s, m_rv;
  int m_ent[$];

  function automatic int ent_val();
    int v = 0;
    int p = 1;
    for (int i = m_ent.size() - 1; i >= 0; i--) begin
      v += m_ent[i] * p;
      p *= 10;
    end
    return v;
  endfunction

  function automatic void m_reset();
    m_phase = 0; m_a = 0; m_b = 0; m_s = 0; m_rv = 0;
    m_ent.delete();
  endfunction

  function automatic void m_key(int code);
    m_rv = 0;
    if (code < 10) begin
      if (m_phase == 2) begin
        m_ent.delete();
        m_ent.push_back(code);
        m_phase = 0;
      end else if (m_ent.size() < MAXD) begin
        m_ent.push_back(code);
      end
    end else if (code == 10) begin
      if (m_phase == 0 && m_ent.size() > 0) begin
        m_a = ent_val(); m_ent.delete(); m_phase = 1;
      end
    end else if (code == 11) begin
      if (m_phase == 1 && m_ent.size() > 0) begin
        m_b = ent_val(); m_s = m_a + m_b; m_ent.delete(); m_rv = 1; m_phase = 2;
      end
    end else if (code == 12) begin
      m_ent.delete();
    end else if (code == 13) begin
      m_reset();
    end
  endfunction

  task automatic drive(input bit r, input bit v, input int code);
    exp_t e;
    @(negedge clk);
    rst       = r;
    key_valid = v;
    key_code  = 4'(code);
    if (r) m_reset();
    else if (v) m_key(code);
    else m_rv = 0;
    e.a  = m_a;
    e.b  = m_b;
    e.s  = m_s;
    e.d  = (m_phase == 2) ? m_s : ent_val();
    e.c  = m_ent.size();
    e.st = m_phase;
    e.rv = m_rv;
    q.push_back(e);
  endtask

  task automatic key(input int code);
    drive(1'b0, 1'b1, code);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, int'($urandom_range(0, 15)));
  endtask

  task automatic chk(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // monitor: compares each expected cycle one time unit after the capturing edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        if (int'(operand_a) != e.a || int'(operand_b) != e.b || int'(sum) != e.s ||
            int'(disp_value) != e.d || int'(digit_count) != e.c ||
            int'(state_o) != e.st || int'(result_valid) != e.rv) begin
          errors++;
          $display("FAIL cycle@%0t: got a=%0d b=%0d s=%0d d=%0d c=%0d st=%0d rv=%0d expected a=%0d b=%0d s=%0d d=%0d c=%0d st=%0d rv=%0d",
                   $time, operand_a, operand_b, sum, disp_value, digit_count, state_o,
                   result_valid, e.a, e.b, e.s, e.d, e.c, e.st, e.rv);
        end
      end
    end
  end

  initial begin
    int x, code;
    rst = 1'b1; key_valid = 1'b0; key_code = 4'd0;
    m_reset();
    #2;
    chk("async_reset_disp", int'(disp_value), 0);
    chk("async_reset_state", int'(state_o), 0);
    drive(1'b1, 1'b0, 0);
    drive(1'b0, 1'b0, 0);

    key(1); key(2); key(10); key(4); key(2); key(11);
    settle();
    chk("r31_sum", int'(sum), 54);
    chk("r31_disp", int'(disp_value), 54);
    chk("r31_state", int'(state_o), 2);
    idle();
    key(7);
    settle();
    chk("r36_state", int'(state_o), 0);
    chk("r36_disp", int'(disp_value), 7);
    chk("r36_sum", int'(sum), 54);

    key(13); key(9); key(9); key(9); key(9);
    settle();
    chk("r32_disp", int'(disp_value), 999);
    chk("r32_count", int'(digit_count), 3);
    key(10); key(9); key(9); idle(); key(9); key(11);
    settle();
    chk("r32_sum", int'(sum), 1998);

    key(13); key(10); key(11); idle();
    settle();
    chk("r33_state", int'(state_o), 0);
    chk("r33_opa", int'(operand_a), 0);

    key(5); key(7); key(12); key(3); key(10);
    settle();
    chk("r34_opa", int'(operand_a), 3);
    key(1); key(13);
    settle();
    chk("r34_clear_state", int'(state_o), 0);
    chk("r34_clear_opa", int'(operand_a), 0);

    key(4); key(5); drive(1'b1, 1'b1, 6); key(6); key(10);
    settle();
    chk("r35_opa", int'(operand_a), 6);
    for (int i = 0; i < 8; i++) idle();

    for (int i = 0; i < 3000; i++) begin
      x = int'($urandom_range(0, 23));
      if (x < 14)      code = x % 10;
      else if (x < 17) code = 10;
      else if (x < 20) code = 11;
      else if (x < 22) code = 12;
      else if (x == 22) code = 13;
      else             code = 14 + int'($urandom_range(0, 1));
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, code);
    end
    drive(1'b0, 1'b0, 0);

    @(posedge clk);
    #3;
    vectors++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/operand_entry_ctrl.md
OPERAND_ENTRY_CTRL -- requirements
Module: operand_entry_ctrl

Interface
REQ-001 Parameter MAX_DIGITS, default 3, maximum decimal digits per operand; legal range 1..3.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-004 key_valid  input  1  one-cycle pulse marking a debounced keypress; key_code meaningful only while high.
REQ-005 key_code  input  4  key: 0-9 digits, 10=A (commit A), 11=B (commit B), 12=C (clear entry), 13=D (clear all), 14/15 ignored.
REQ-006 operand_a  output  10  committed operand A, binary.
REQ-007 operand_b  output  10  committed operand B, binary.
REQ-008 sum  output  11  operand_a + operand_b, binary, max 1998.
REQ-009 disp_value  output  14  binary value for the 4-digit display path.
REQ-010 digit_count  output  2  digits in the current entry, 0..MAX_DIGITS.
REQ-011 state_o  output  2  FSM state: 00=ENTER_A, 01=ENTER_B, 10=SHOW_RESULT.
REQ-012 result_valid  output  1  one-cycle pulse when sum is updated.

Function
REQ-013 Every output shall be registered; each key effect is visible on outputs exactly 1 cycle after the key_valid cycle.
REQ-014 An internal accumulator acc (10 bits) shall hold the entry in progress.
REQ-015 key_valid low: no state, register or output change; result_valid low.
REQ-016 Digit in ENTER_A/ENTER_B with digit_count < MAX_DIGITS: acc <= acc*10 + digit; digit_count += 1.
REQ-017 Digit with digit_count == MAX_DIGITS: ignored; acc and digit_count unchanged.
REQ-018 A in ENTER_A with digit_count > 0: operand_a <= acc; acc <= 0; digit_count <= 0; go to ENTER_B.
REQ-019 A in ENTER_A with digit_count == 0: ignored; operand_a is not zeroed.
REQ-020 B in ENTER_B with digit_count > 0: operand_b <= acc; sum <= operand_a + acc; acc <= 0; digit_count <= 0; result_valid high for that 1 cycle; go to SHOW_RESULT.
REQ-021 B in ENTER_B with digit_count == 0: ignored.
REQ-022 A in ENTER_B, B in ENTER_A, A/B in SHOW_RESULT, and codes 14/15 in any state: ignored.
REQ-023 C in any state: acc <= 0; digit_count <= 0; state, operands and sum unchanged.
REQ-024 D in any state: same values as reset (REQ-028).
REQ-025 Digit in SHOW_RESULT: acc <= digit; digit_count <= 1; go to ENTER_A; operand_a, operand_b and sum held until the next commit.
REQ-026 disp_value shall be zero-extended acc in ENTER_A/ENTER_B and zero-extended sum in SHOW_RESULT.
REQ-027 sum shall be computed at full 11-bit width with no truncation or wrap.

Reset
REQ-028 rst high shall immediately force state_o=00, acc=0, digit_count=0, operand_a=0, operand_b=0, sum=0, disp_value=0, result_valid=0.
REQ-029 rst shall win over a simultaneous key_valid; no key captured in a reset cycle takes effect.
REQ-030 Reset mid-entry shall discard the partial entry; the first key after release starts a fresh ENTER_A.

Verification
REQ-031 Keys 1,2,A,4,2,B -> operand_a=12, operand_b=42, sum=54, disp_value=54, state_o=10, result_valid exactly one pulse.
REQ-032 Keys 9,9,9,9 -> acc/disp_value=999, digit_count=3, fourth digit ignored; then A,9,9,9,B -> sum=1998.
REQ-033 A with no digits in ENTER_A, then B in ENTER_A -> state_o stays 00, operand_a=0, no result_valid.
REQ-034 Keys 5,7,C,3,A -> operand_a=3; keys 1,D -> all outputs at reset values.
REQ-035 Keys 4,5 then rst pulse mid-entry, then 6,A -> operand_a=6; key_valid held low while key_code toggles -> no change.
REQ-036 After REQ-031 sequence, key 7 -> state_o=00, disp_value=7, sum still 54.
